// File: rtl/csa_nibble_serial_adder.sv
// ============================================================================
// Module   : csa_nibble_serial_adder
// Summary  : WIDTH-bit adder that reuses one 4-bit carry-select slice, one
//            nibble per clock, LSB nibble first. Optional macro SIGNED_OVF_EN
//            adds a registered signed-overflow output (ovf).
// Revision : 1.0
// ============================================================================
`default_nettype none

module csa_nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
`ifdef SIGNED_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q;

   logic [3:0]       a_nib, b_nib;
   logic [4:0]       slice_s0, slice_s1, slice_s;
   logic             w_accept;
   logic             w_last;

   assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign w_last   = (idx_q == IDXW'(NIBBLES - 1));

   // Operand nibble selection for the current pass
   always_comb begin
      a_nib = 4'h0;
      b_nib = 4'h0;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == IDXW'(n)) begin
            a_nib = a_q[4*n +: 4];
            b_nib = b_q[4*n +: 4];
         end
      end
   end

   // Carry-select slice: both carry-in cases precomputed, registered carry picks one
   assign slice_s0 = {1'b0, a_nib} + {1'b0, b_nib};
   assign slice_s1 = slice_s0 + 5'd1;
   assign slice_s  = carry_q ? slice_s1 : slice_s0;

   always_comb begin
      sum_d = sum_q;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == IDXW'(n)) begin
            sum_d[4*n +: 4] = slice_s[3:0];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = start ? S_RUN : S_IDLE;
         S_RUN:   state_d = w_last ? S_DONE : S_RUN;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
      end else if (w_accept) begin
         idx_q   <= '0;
         carry_q <= ci;
         a_q     <= a;
         b_q     <= b;
      end else if (state_q == S_RUN) begin
         sum_q   <= sum_d;
         carry_q <= slice_s[4];
         idx_q   <= idx_q + IDXW'(1);
         if (w_last) begin
            co_q <= slice_s[4];
         end
      end
   end

   assign sum = sum_q;
   assign co  = co_q;

`ifdef SIGNED_OVF_EN
   logic ovf_q;

   // Final slice nibble bit 3 is the MSB of the completed sum
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (!w_accept && (state_q == S_RUN) && w_last) begin
         ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_csa_nibble_serial_adder
// Summary  : Self-checking bench for csa_nibble_serial_adder (WIDTH=16) against
//            a plain-arithmetic reference; honours SIGNED_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csa_nibble_serial_adder;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             ci;
   logic             busy, done;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ovf;

   int checks;
   int failures;

   csa_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .co    (co)
`ifdef SIGNED_OVF_EN
     ,.ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one add at the current negedge and waits (bounded) for done.
   // lat counts cycles from the start edge to the cycle done is seen.
   task automatic do_add(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ici,
                         output logic [WIDTH-1:0] osum, output logic oco,
                         output logic oovf, output int olat, output int obusy,
                         output bit ook);
      a = ia; b = ib; ci = ici; start = 1'b1;
      olat = 0; obusy = 0; ook = 1'b0;
      osum = '0; oco = 1'b0; oovf = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 20 && !ook; n++) begin
         if (busy) obusy++;
         if (done) begin
            ook  = 1'b1;
            olat = n - 1;
            osum = sum;
            oco  = co;
            oovf = ovf;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      logic [WIDTH-1:0] s; logic c, o; int lat, bc; bit ok;
      logic [WIDTH:0] exp;
      logic [WIDTH-1:0] ra, rb; logic rci;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, co} !== 3'b000 || sum !== '0) begin
         failures++;
         $display("FAIL reset_state busy=%b done=%b co=%b sum=%h required all zero", busy, done, co, sum);
      end
      // Reset mid-RUN after two nibbles have been written
      a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, co} !== 3'b000 || sum !== '0) begin
         failures++;
         $display("FAIL reset_midrun busy=%b done=%b co=%b sum=%h required all zero", busy, done, co, sum);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_stays_idle busy=%b done=%b required 0 0", busy, done);
      end
      ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rci};
      do_add(ra, rb, rci, s, c, o, lat, bc, ok);
      checks++;
      if (!ok || {c, s} !== exp || lat != 4) begin
         failures++;
         $display("FAIL reset_then_add ok=%0d lat=%0d got=%h required=%h lat 4", ok, lat, {c, s}, exp);
      end
   endtask

   task automatic test_ripple();
      logic [WIDTH-1:0] s; logic c, o; int lat, bc; bit ok;
      @(negedge clk);
      do_add(16'hFFFF, 16'h0001, 1'b0, s, c, o, lat, bc, ok);
      checks++;
      if (!ok || lat != 4) begin
         failures++;
         $display("FAIL ripple_latency ok=%0d lat=%0d required 4", ok, lat);
      end
      checks++;
      if (s !== 16'h0000 || c !== 1'b1) begin
         failures++;
         $display("FAIL ripple_result sum=%h co=%b required 0000 1", s, c);
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] s; logic c, o; int lat, bc; bit ok;
      @(negedge clk);
      do_add(16'h1234, 16'h4321, 1'b1, s, c, o, lat, bc, ok);
      checks++;
      if (!ok || s !== 16'h5556 || c !== 1'b0) begin
         failures++;
         $display("FAIL basic_result ok=%0d sum=%h co=%b required 5556 0", ok, s, c);
      end
      checks++;
      if (bc != 4) begin
         failures++;
         $display("FAIL basic_busy_cycles got=%0d required 4", bc);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy_with_done busy=%b required 0", busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sum !== 16'h5556) begin
         failures++;
         $display("FAIL basic_done_width done=%b sum=%h required 0 5556", done, sum);
      end
   endtask

   task automatic test_back_to_back();
      int ndone, last_cyc;
      @(negedge clk);
      start = 1'b1; a = 16'h8000; b = 16'h8000; ci = 1'b0;
      ndone = 0; last_cyc = -1;
      for (int cyc = 0; cyc < 23; cyc++) begin
         if (done) begin
            ndone++;
            checks++;
            if (sum !== 16'h0000 || co !== 1'b1 || busy !== 1'b0) begin
               failures++;
               $display("FAIL b2b_result sum=%h co=%b busy=%b required 0000 1 0", sum, co, busy);
            end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != 5) begin
                  failures++;
                  $display("FAIL b2b_period got=%0d required 5", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
         end
         if (busy) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
         end else begin
            a = 16'h8000; b = 16'h8000; ci = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (ndone < 4) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d required >=4", ndone);
      end
      for (int k = 0; k < 10 && (busy || done); k++) @(negedge clk);
   endtask

`ifdef SIGNED_OVF_EN
   task automatic test_ovf();
      logic [WIDTH-1:0] s; logic c, o; int lat, bc; bit ok;
      @(negedge clk);
      do_add(16'h7FFF, 16'h0001, 1'b0, s, c, o, lat, bc, ok);
      checks++;
      if (!ok || o !== 1'b1 || s !== 16'h8000 || c !== 1'b0) begin
         failures++;
         $display("FAIL ovf_pos ovf=%b sum=%h co=%b required 1 8000 0", o, s, c);
      end
      @(negedge clk);
      do_add(16'hFFFF, 16'h0001, 1'b0, s, c, o, lat, bc, ok);
      checks++;
      if (!ok || o !== 1'b0 || c !== 1'b1) begin
         failures++;
         $display("FAIL ovf_neg ovf=%b co=%b required 0 1", o, c);
      end
   endtask
`endif

   task automatic test_random();
      logic [WIDTH-1:0] s, ra, rb, psum; logic c, o, rci, pco; int lat, bc; bit ok;
      logic [WIDTH:0] exp;
      logic eovf;
      bit have_prev;
      int gap;
      have_prev = 1'b0; psum = '0; pco = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (have_prev) begin
               checks++;
               if (sum !== psum || co !== pco) begin
                  failures++;
                  $display("FAIL rand_hold sum=%h co=%b required %h %b", sum, co, psum, pco);
               end
            end
         end
         ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
         exp  = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rci};
         eovf = (ra[WIDTH-1] == rb[WIDTH-1]) && (exp[WIDTH-1] != ra[WIDTH-1]);
         do_add(ra, rb, rci, s, c, o, lat, bc, ok);
         checks++;
         if (!ok || {c, s} !== exp || lat != 4) begin
            failures++;
            $display("FAIL rand_add a=%h b=%h ci=%b ok=%0d lat=%0d got=%h required=%h", ra, rb, rci, ok, lat, {c, s}, exp);
         end
`ifdef SIGNED_OVF_EN
         checks++;
         if (o !== eovf) begin
            failures++;
            $display("FAIL rand_ovf a=%h b=%h got=%b required=%b", ra, rb, o, eovf);
         end
`else
         if (eovf === 1'bx) $display("note: unexpected x in overflow model");
`endif
         psum = exp[WIDTH-1:0]; pco = exp[WIDTH];
         have_prev = ok;
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
      test_reset();
      test_ripple();
      test_basic();
      test_back_to_back();
`ifdef SIGNED_OVF_EN
      test_ovf();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
